hazard_forward_ctrl: RTL and testbench

//  Parametrised forwarding and hazard controller for the 5-stage RISC-V pipeline.
//  - Generates per-source-port bypass selects for the EX stage.
//  - Detects load-use hazards and runs a multi-cycle stall FSM.
//  - Converts a taken branch into IF/ID and ID/EX flushes.
//  - Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_forward_if.sv | 41 ++++
 rtl/hazard_forward_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_if.sv
// Pipeline hazard/forwarding bus between the pipeline datapath (master) and the
// hazard controller (slave).
interface hazard_forward_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] in_idex_rs;
    logic [NUM_SRC-1:0]        in_idex_rs_used;
    logic [NUM_SRC*REG_AW-1:0] in_ifid_rs;
    logic [NUM_SRC-1:0]        in_ifid_rs_used;
    logic                      in_idex_memread;
    logic [REG_AW-1:0]         in_idex_rd;
    logic                      in_exmem_regwrite;
    logic [REG_AW-1:0]         in_exmem_rd;
    logic                      in_memwb_regwrite;
    logic [REG_AW-1:0]         in_memwb_rd;
    logic                      in_branch_taken;
    logic [2*NUM_SRC-1:0]      out_forward_sel;
    logic                      out_pc_write;
    logic                      out_ifid_write;
    logic                      out_idex_bubble;
    logic                      out_ifid_flush;
    logic [CNT_W-1:0]          out_stall_cycles;

    modport master (
        output in_idex_rs, in_idex_rs_used, in_ifid_rs, in_ifid_rs_used,
               in_idex_memread, in_idex_rd, in_exmem_regwrite, in_exmem_rd,
               in_memwb_regwrite, in_memwb_rd, in_branch_taken,
        input  out_forward_sel, out_pc_write, out_ifid_write, out_idex_bubble,
               out_ifid_flush, out_stall_cycles
    );

    modport slave (
        input  in_idex_rs, in_idex_rs_used, in_ifid_rs, in_ifid_rs_used,
               in_idex_memread, in_idex_rd, in_exmem_regwrite, in_exmem_rd,
               in_memwb_regwrite, in_memwb_rd, in_branch_taken,
        output out_forward_sel, out_pc_write, out_ifid_write, out_idex_bubble,
               out_ifid_flush, out_stall_cycles
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select, load-use stall FSM, branch flush and saturating
// stall-cycle counter for a 5-stage RISC-V pipeline.
//
// state | meaning
// IDLE  | normal flow; a load-use hazard stalls here for its first cycle
// STALL | extra load-use stall cycles, cnt_q counts the remaining ones
module hazard_forward_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    hazard_forward_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [2*NUM_SRC-1:0] fwd_sel;
    logic               lu_hit;
    logic               lu;
    logic               pc_write;
    logic               ifid_write;
    logic               bubble;
    logic               flush;

    always_comb begin
        fwd_sel = '0;
        lu_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.in_idex_rs_used[i] && bus.in_exmem_regwrite && (bus.in_exmem_rd != '0)
                && (bus.in_exmem_rd == bus.in_idex_rs[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (bus.in_idex_rs_used[i] && bus.in_memwb_regwrite && (bus.in_memwb_rd != '0)
                && (bus.in_memwb_rd == bus.in_idex_rs[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end
            if (bus.in_ifid_rs_used[i] && (bus.in_ifid_rs[i*REG_AW +: REG_AW] == bus.in_idex_rd)) begin
                lu_hit = 1'b1;
            end
        end
        lu = bus.in_idex_memread && (bus.in_idex_rd != '0) && lu_hit;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.in_branch_taken && lu && (LOAD_STALL > 1)) begin
                    state_d = STALL;
                    cnt_d   = 3'(LOAD_STALL - 2);
                end
            end
            STALL: begin
                if (bus.in_branch_taken || (cnt_q == 3'd0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A branch resolved in EX squashes the dependent instruction, so it wins over any stall.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        flush      = 1'b0;
        if (!in_rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_branch_taken) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        bubble     = 1'b1;
                    end
                end
                STALL: begin
                    bubble = 1'b1;
                    if (bus.in_branch_taken) begin
                        flush = 1'b1;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus.out_forward_sel  = in_rst ? '0 : fwd_sel;
    assign bus.out_pc_write     = pc_write;
    assign bus.out_ifid_write   = ifid_write;
    assign bus.out_idex_bubble  = bubble;
    assign bus.out_ifid_flush   = flush;
    assign bus.out_stall_cycles = in_rst ? '0 : stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Drives three controller configurations with shared stimulus and compares each
// against a cycle-level model built from remaining-stall counts.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] s_idex_rs, s_ifid_rs;
    logic [1:0] s_idex_used, s_ifid_used;
    logic       s_memread, s_exmem_rw, s_memwb_rw, s_br, s_rst;
    logic [4:0] s_idex_rd, s_exmem_rd, s_memwb_rd;

    int n_checks = 0;
    int n_errors = 0;

    int ls[3]   = '{1, 3, 1};
    int smax[3] = '{65535, 65535, 15};
    int rem[3]  = '{0, 0, 0};
    int stat[3] = '{0, 0, 0};

    hazard_forward_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if_a ();
    hazard_forward_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if_b ();
    hazard_forward_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  if_c ();

    assign if_a.in_idex_rs = s_idex_rs;        assign if_b.in_idex_rs = s_idex_rs;        assign if_c.in_idex_rs = s_idex_rs;
    assign if_a.in_idex_rs_used = s_idex_used; assign if_b.in_idex_rs_used = s_idex_used; assign if_c.in_idex_rs_used = s_idex_used;
    assign if_a.in_ifid_rs = s_ifid_rs;        assign if_b.in_ifid_rs = s_ifid_rs;        assign if_c.in_ifid_rs = s_ifid_rs;
    assign if_a.in_ifid_rs_used = s_ifid_used; assign if_b.in_ifid_rs_used = s_ifid_used; assign if_c.in_ifid_rs_used = s_ifid_used;
    assign if_a.in_idex_memread = s_memread;   assign if_b.in_idex_memread = s_memread;   assign if_c.in_idex_memread = s_memread;
    assign if_a.in_idex_rd = s_idex_rd;        assign if_b.in_idex_rd = s_idex_rd;        assign if_c.in_idex_rd = s_idex_rd;
    assign if_a.in_exmem_regwrite = s_exmem_rw; assign if_b.in_exmem_regwrite = s_exmem_rw; assign if_c.in_exmem_regwrite = s_exmem_rw;
    assign if_a.in_exmem_rd = s_exmem_rd;      assign if_b.in_exmem_rd = s_exmem_rd;      assign if_c.in_exmem_rd = s_exmem_rd;
    assign if_a.in_memwb_regwrite = s_memwb_rw; assign if_b.in_memwb_regwrite = s_memwb_rw; assign if_c.in_memwb_regwrite = s_memwb_rw;
    assign if_a.in_memwb_rd = s_memwb_rd;      assign if_b.in_memwb_rd = s_memwb_rd;      assign if_c.in_memwb_rd = s_memwb_rd;
    assign if_a.in_branch_taken = s_br;        assign if_b.in_branch_taken = s_br;        assign if_c.in_branch_taken = s_br;

    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(1), .CNT_W(16)) dut_a (
        .in_clk(clk), .in_rst(s_rst), .bus(if_a.slave));
    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(3), .CNT_W(16)) dut_b (
        .in_clk(clk), .in_rst(s_rst), .bus(if_b.slave));
    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_STALL(1), .CNT_W(4)) dut_c (
        .in_clk(clk), .in_rst(s_rst), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_sel();
        logic [3:0] sel = 4'b0;
        for (int i = 0; i < 2; i++) begin
            if (s_idex_used[i] && s_exmem_rw && s_exmem_rd != 0 && s_exmem_rd == s_idex_rs[5*i +: 5])
                sel[2*i +: 2] = 2'b10;
            else if (s_idex_used[i] && s_memwb_rw && s_memwb_rd != 0 && s_memwb_rd == s_idex_rs[5*i +: 5])
                sel[2*i +: 2] = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic model_lu();
        return s_memread && (s_idex_rd != 0) &&
               ((s_ifid_used[0] && s_ifid_rs[4:0] == s_idex_rd) ||
                (s_ifid_used[1] && s_ifid_rs[9:5] == s_idex_rd));
    endfunction

    task automatic check_dut(input int k, input logic [3:0] sel, input logic pcw, input logic ifw,
                             input logic bub, input logic fl, input logic [15:0] sc);
        int e_sel = 0, e_pc = 1, e_bub = 0, e_fl = 0, e_sc = 0;
        logic lu = model_lu();
        if (!s_rst) begin
            e_sel = int'(model_sel());
            e_sc  = stat[k];
            if (rem[k] > 0) begin
                e_bub = 1; e_fl = s_br; e_pc = s_br;
            end else if (s_br) begin
                e_bub = 1; e_fl = 1;
            end else if (lu) begin
                e_bub = 1; e_pc = 0;
            end
        end
        chk($sformatf("d%0d_sel", k), 32'(sel), 32'(e_sel));
        chk($sformatf("d%0d_pc_write", k), 32'(pcw), 32'(e_pc));
        chk($sformatf("d%0d_ifid_write", k), 32'(ifw), 32'(e_pc));
        chk($sformatf("d%0d_bubble", k), 32'(bub), 32'(e_bub));
        chk($sformatf("d%0d_flush", k), 32'(fl), 32'(e_fl));
        chk($sformatf("d%0d_stall_cycles", k), 32'(sc), 32'(e_sc));
        if (s_rst) begin
            rem[k] = 0; stat[k] = 0;
        end else begin
            if (rem[k] > 0) rem[k] = s_br ? 0 : rem[k] - 1;
            else if (!s_br && lu) rem[k] = ls[k] - 1;
            if (e_pc == 0 && stat[k] < smax[k]) stat[k]++;
        end
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1-2 time units later.
    task automatic step();
        #2;
        check_dut(0, if_a.out_forward_sel, if_a.out_pc_write, if_a.out_ifid_write,
                  if_a.out_idex_bubble, if_a.out_ifid_flush, if_a.out_stall_cycles);
        check_dut(1, if_b.out_forward_sel, if_b.out_pc_write, if_b.out_ifid_write,
                  if_b.out_idex_bubble, if_b.out_ifid_flush, if_b.out_stall_cycles);
        check_dut(2, if_c.out_forward_sel, if_c.out_pc_write, if_c.out_ifid_write,
                  if_c.out_idex_bubble, if_c.out_ifid_flush, {12'b0, if_c.out_stall_cycles});
        @(negedge clk);
    endtask

    task automatic clear_stim();
        s_idex_rs = '0; s_ifid_rs = '0; s_idex_used = '0; s_ifid_used = '0;
        s_memread = 0; s_exmem_rw = 0; s_memwb_rw = 0; s_br = 0;
        s_idex_rd = '0; s_exmem_rd = '0; s_memwb_rd = '0;
    endtask

    task automatic rand_stim();
        s_idex_rs   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        s_ifid_rs   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        s_idex_used = 2'($urandom);
        s_ifid_used = 2'($urandom);
        s_memread   = ($urandom_range(0, 2) == 0);
        s_idex_rd   = 5'($urandom_range(0, 7));
        s_exmem_rw  = 1'($urandom);
        s_exmem_rd  = 5'($urandom_range(0, 7));
        s_memwb_rw  = 1'($urandom);
        s_memwb_rd  = 5'($urandom_range(0, 7));
        s_br        = ($urandom_range(0, 9) == 0);
    endtask

    task automatic do_reset();
        clear_stim();
        s_rst = 1;
        step();
        s_rst = 0;
    endtask

    task automatic set_load_use();
        s_memread = 1; s_idex_rd = 5'd7; s_ifid_rs = {5'd7, 5'd3}; s_ifid_used = 2'b10;
    endtask

    initial begin
        clear_stim();
        s_rst = 1;
        for (int i = 0; i < 2; i++) begin
            rand_stim();
            #1 chk("rst_sel", 32'(if_a.out_forward_sel), 32'd0);
            chk("rst_bubble", 32'(if_b.out_idex_bubble), 32'd0);
            step();
        end
        s_rst = 0;

        clear_stim();
        s_exmem_rw = 1; s_memwb_rw = 1; s_exmem_rd = 5'd5; s_memwb_rd = 5'd5;
        s_idex_rs = {5'd0, 5'd5}; s_idex_used = 2'b01;
        #1 chk("dual_match", 32'(if_a.out_forward_sel[1:0]), 32'h2);
        step();
        s_idex_used = 2'b00;
        #1 chk("dual_unused", 32'(if_a.out_forward_sel[1:0]), 32'h0);
        step();
        s_idex_used = 2'b01; s_exmem_rd = 5'd0; s_memwb_rd = 5'd0; s_idex_rs = '0;
        #1 chk("dual_rd0", 32'(if_a.out_forward_sel[1:0]), 32'h0);
        step();

        do_reset();
        set_load_use();
        step();
        clear_stim();
        for (int i = 0; i < 4; i++) step();
        #1 chk("lu1_count", 32'(if_a.out_stall_cycles), 32'd1);
        chk("lu3_count", 32'(if_b.out_stall_cycles), 32'd3);
        step();

        do_reset();
        set_load_use(); s_br = 1;
        #1 chk("br_lu_flush", 32'(if_b.out_ifid_flush), 32'd1);
        step();
        s_br = 0;
        step();
        clear_stim(); s_br = 1;
        #1 chk("br_stall_flush", 32'(if_b.out_ifid_flush), 32'd1);
        step();
        s_br = 0;
        step();
        #1 chk("br_stall_count", 32'(if_b.out_stall_cycles), 32'd1);
        step();

        do_reset();
        set_load_use();
        for (int i = 0; i < 20; i++) step();
        clear_stim();
        #1 chk("sat_count", 32'(if_c.out_stall_cycles), 32'd15);
        step();

        set_load_use();
        step();
        clear_stim();
        s_rst = 1;
        step();
        s_rst = 0;
        #1 chk("midrst_count", 32'(if_b.out_stall_cycles), 32'd0);
        chk("midrst_pc", 32'(if_b.out_pc_write), 32'd1);
        step();

        for (int i = 0; i < 2000; i++) begin
            rand_stim();
            s_rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
